// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller for the PmodADC serial-in/latched shift-register DAC.
// Latency: 1 + SAMPLE_CYCLES + N*(2*CLK_DIV*(SR_W+1) + SETTLE_CYCLES + 1) cycles from accepted start to valid_o.
// Backpressure: none; start_i is only accepted in IDLE and is otherwise dropped, never queued.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   start_i          conversion request (IDLE only)
//   comp_i           comparator, 1 = DAC trial voltage <= input
//   sh_o             sample/hold (1 = track)
//   ser_o/sclk_o/lclk_o  serial data, shift clock, latch clock to the DAC shift register
//   busy_o, valid_o, data_o  handshake and result (data_o held until next valid_o)
//
// Optional macro SAR_COMP_SYNC_EN: routes comp_i through a 2-flop synchroniser and
// lengthens SETTLE by 2 cycles to cover the synchroniser delay (latency + 2*N).
module sar_adc_ctrl #(
   parameter int N             = 14,
   parameter int SR_W          = 16,
   parameter int CLK_DIV       = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int SAMPLE_CYCLES = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic         comp_i,
   output logic         sh_o,
   output logic         ser_o,
   output logic         sclk_o,
   output logic         lclk_o,
   output logic         busy_o,
   output logic         valid_o,
   output logic [N-1:0] data_o
);

`ifdef SAR_COMP_SYNC_EN
   localparam int SYNC_EXTRA = 2;
`else
   localparam int SYNC_EXTRA = 0;
`endif
   localparam int SETTLE_EFF = SETTLE_CYCLES + SYNC_EXTRA;
   localparam int MAX_AB     = (SR_W > SAMPLE_CYCLES) ? SR_W : SAMPLE_CYCLES;
   localparam int MAX_CD     = (SETTLE_EFF > CLK_DIV) ? SETTLE_EFF : CLK_DIV;
   localparam int MAX_CNT    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW         = $clog2(MAX_CNT + 1);
   localparam int KW         = (N > 1) ? $clog2(N) : 1;

   localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
   localparam logic [CW-1:0] SHIFT_LAST  = CW'(SR_W - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_EFF - 1);
   localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
   localparam logic [KW-1:0] K_MSB       = KW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SAMPLE, S_SHIFT, S_LATCH, S_SETTLE, S_DECIDE, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;     // sample/settle cycles, or bit index while shifting
   logic [CW-1:0]   div_q, div_d;     // cycles within one SClk/LClk half-period
   logic            half_q, half_d;   // 0 = first half-period, 1 = second
   logic [KW-1:0]   k_q, k_d;         // bit currently being resolved
   logic [N-1:0]    res_q, res_d;
   logic [SR_W-1:0] sreg_q, sreg_d;   // trial word being shifted out, MSB at top
   logic [N-1:0]    data_q, data_d;

   logic            comp_s;
   logic [N-1:0]    res_dec;
   logic [KW-1:0]   k_nxt;
   logic            half_end;

`ifdef SAR_COMP_SYNC_EN
   logic comp_meta_q, comp_sync_q;
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         comp_meta_q <= 1'b0;
         comp_sync_q <= 1'b0;
      end else begin
         comp_meta_q <= comp_i;
         comp_sync_q <= comp_meta_q;
      end
   end
   assign comp_s = comp_sync_q;
`else
   assign comp_s = comp_i;
`endif

   // Trial word is left-aligned in the external register.
   function automatic logic [SR_W-1:0] align(input logic [N-1:0] t);
      return SR_W'(t) << (SR_W - N);
   endfunction

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         half_q  <= 1'b0;
         k_q     <= '0;
         res_q   <= '0;
         sreg_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         half_q  <= half_d;
         k_q     <= k_d;
         res_q   <= res_d;
         sreg_q  <= sreg_d;
         data_q  <= data_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      half_d   = half_q;
      k_d      = k_q;
      res_d    = res_q;
      sreg_d   = sreg_q;
      data_d   = data_q;
      res_dec  = res_q;
      res_dec[k_q] = comp_s;
      k_nxt    = k_q - 1'b1;
      half_end = (div_q == DIV_LAST);

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_SAMPLE;
               cnt_d   = '0;
               k_d     = K_MSB;
               res_d   = '0;
            end
         end
         S_SAMPLE: begin
            if (cnt_q == SAMPLE_LAST) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
               div_d   = '0;
               half_d  = 1'b0;
               sreg_d  = align(N'(1) << k_q);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (half_end) begin
               div_d  = '0;
               half_d = ~half_q;
               // End of the high half: next bit is presented while sclk is low.
               if (half_q) begin
                  sreg_d = sreg_q << 1;
                  if (cnt_q == SHIFT_LAST) begin
                     state_d = S_LATCH;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_LATCH: begin
            if (half_end) begin
               div_d  = '0;
               half_d = ~half_q;
               if (half_q) begin
                  state_d = (SETTLE_EFF == 0) ? S_DECIDE : S_SETTLE;
                  cnt_d   = '0;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = S_DECIDE;
            else                      cnt_d   = cnt_q + 1'b1;
         end
         S_DECIDE: begin
            res_d = res_dec;
            if (k_q == '0) begin
               data_d  = res_dec;
               state_d = S_DONE;
            end else begin
               k_d     = k_nxt;
               state_d = S_SHIFT;
               cnt_d   = '0;
               div_d   = '0;
               half_d  = 1'b0;
               sreg_d  = align(res_dec | (N'(1) << k_nxt));
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state and registers
   always_comb begin
      sh_o    = (state_q == S_IDLE) || (state_q == S_SAMPLE) || (state_q == S_DONE);
      ser_o   = (state_q == S_SHIFT) && sreg_q[SR_W-1];
      sclk_o  = (state_q == S_SHIFT) && half_q;
      lclk_o  = (state_q == S_LATCH) && !half_q;
      busy_o  = (state_q != S_IDLE);
      valid_o = (state_q == S_DONE);
   end

   assign data_o = data_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
module tb_sar_adc_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0;
   logic comp_a, comp_b;
   logic sh_a, ser_a, sclk_a, lclk_a, busy_a, valid_a;
   logic sh_b, ser_b, sclk_b, lclk_b, busy_b, valid_b;
   logic [13:0] data_a;
   logic [7:0]  data_b;
   logic [13:0] val_a = 14'h2A52;
   logic [7:0]  val_b = 8'hA5;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sar_adc_ctrl dut_a (
      .clk_i(clk), .reset_i(rst), .start_i(start_a), .comp_i(comp_a),
      .sh_o(sh_a), .ser_o(ser_a), .sclk_o(sclk_a), .lclk_o(lclk_a),
      .busy_o(busy_a), .valid_o(valid_a), .data_o(data_a)
   );

   sar_adc_ctrl #(.N(8), .SR_W(12), .CLK_DIV(1), .SETTLE_CYCLES(0), .SAMPLE_CYCLES(8)) dut_b (
      .clk_i(clk), .reset_i(rst), .start_i(start_b), .comp_i(comp_b),
      .sh_o(sh_b), .ser_o(ser_b), .sclk_o(sclk_b), .lclk_o(lclk_b),
      .busy_o(busy_b), .valid_o(valid_b), .data_o(data_b)
   );

   // DAC shift/latch register models with ideal comparators
   logic [15:0] sr_a = '0, lat_a = '0, first_a = '0;
   logic [11:0] sr_b = '0, lat_b = '0, first_b = '0;
   logic sclk_p_a = 0, lclk_p_a = 0, busy_p_a = 0;
   logic sclk_p_b = 0, lclk_p_b = 0, busy_p_b = 0;
   int lclk_cnt_a = 0, sclk_since_a = 0, sclk_bad_a = 0;
   int lclk_cnt_b = 0, sclk_since_b = 0, sclk_bad_b = 0;

   assign comp_a = ((lat_a >> 2) <= 16'(val_a));
   assign comp_b = ((lat_b >> 4) <= 12'(val_b));

   always @(negedge clk) begin
      if (busy_a && !busy_p_a) begin lclk_cnt_a = 0; sclk_since_a = 0; sclk_bad_a = 0; end
      if (sclk_a && !sclk_p_a) begin sr_a = {sr_a[14:0], ser_a}; sclk_since_a++; end
      if (lclk_a && !lclk_p_a) begin
         lat_a = sr_a;
         if (lclk_cnt_a == 0) first_a = sr_a;
         lclk_cnt_a++;
         if (sclk_since_a != 16) sclk_bad_a++;
         sclk_since_a = 0;
      end
      sclk_p_a = sclk_a; lclk_p_a = lclk_a; busy_p_a = busy_a;

      if (busy_b && !busy_p_b) begin lclk_cnt_b = 0; sclk_since_b = 0; sclk_bad_b = 0; end
      if (sclk_b && !sclk_p_b) begin sr_b = {sr_b[10:0], ser_b}; sclk_since_b++; end
      if (lclk_b && !lclk_p_b) begin
         lat_b = sr_b;
         if (lclk_cnt_b == 0) first_b = sr_b;
         lclk_cnt_b++;
         if (sclk_since_b != 12) sclk_bad_b++;
         sclk_since_b = 0;
      end
      sclk_p_b = sclk_b; lclk_p_b = lclk_b; busy_p_b = busy_b;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Pulses start and returns with the bench sitting in the valid_o cycle
   // (or at the cycle budget); lat is counted from the cycle start was sampled.
   task automatic run_conv(input bit b, input bit keep_start, input string tag, output int lat);
      int sh_bad = 0;
      int busy_bad = 0;
      @(posedge clk); #1;
      chk({tag, " idle busy"}, b ? busy_b : busy_a, 0);
      if (b) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      if (!keep_start) begin start_a = 1'b0; start_b = 1'b0; end
      lat = 1;
      while (!(b ? valid_b : valid_a) && lat < 3000) begin
         if ((b ? sh_b : sh_a) != (lat <= 8)) sh_bad++;
         if (!(b ? busy_b : busy_a)) busy_bad++;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " sh pattern"}, sh_bad, 0);
      chk({tag, " busy during conv"}, busy_bad, 0);
      chk({tag, " sh at valid"}, b ? sh_b : sh_a, 1);
   endtask

   typedef struct {
      bit          inst_b;
      logic [13:0] val;
      logic [13:0] exp_data;
      int          exp_lat;
      logic [15:0] exp_first;
      int          exp_lclk;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int lat;
      int seen;
      vecs[0] = '{0, 14'h2A52, 14'h2A52, 1031, 16'h8000, 14};
      vecs[1] = '{0, 14'h0000, 14'h0000, 1031, 16'h8000, 14};
      vecs[2] = '{0, 14'h3FFF, 14'h3FFF, 1031, 16'h8000, 14};
      vecs[3] = '{0, 14'h0001, 14'h0001, 1031, 16'h8000, 14};
      vecs[4] = '{0, 14'h2000, 14'h2000, 1031, 16'h8000, 14};
      vecs[5] = '{1, 14'h00A5, 14'h00A5, 225,  16'h0800, 8};
      vecs[6] = '{1, 14'h0000, 14'h0000, 225,  16'h0800, 8};
      vecs[7] = '{1, 14'h00FF, 14'h00FF, 225,  16'h0800, 8};
      vecs[8] = '{1, 14'h0080, 14'h0080, 225,  16'h0800, 8};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset outs a", {sh_a, ser_a, sclk_a, lclk_a, busy_a, valid_a}, 6'b100000);
      chk("reset data a", data_a, 0);
      chk("reset outs b", {sh_b, ser_b, sclk_b, lclk_b, busy_b, valid_b}, 6'b100000);
      chk("reset data b", data_b, 0);
      rst = 1'b0;

      // Table-driven conversions
      for (int i = 0; i < 9; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         if (vecs[i].inst_b) val_b = vecs[i].val[7:0]; else val_a = vecs[i].val;
         run_conv(vecs[i].inst_b, 1'b0, tag, lat);
         chk({tag, " latency"}, lat, vecs[i].exp_lat);
         chk({tag, " data"}, vecs[i].inst_b ? 14'(data_b) : data_a, vecs[i].exp_data);
         chk({tag, " first latched"}, vecs[i].inst_b ? 16'(first_b) : first_a, vecs[i].exp_first);
         chk({tag, " lclk count"}, vecs[i].inst_b ? lclk_cnt_b : lclk_cnt_a, vecs[i].exp_lclk);
         chk({tag, " sclk per lclk"}, vecs[i].inst_b ? sclk_bad_b : sclk_bad_a, 0);
         @(posedge clk); #1;
         chk({tag, " valid/busy after"}, vecs[i].inst_b ? {valid_b, busy_b} : {valid_a, busy_a}, 2'b00);
         chk({tag, " data held"}, vecs[i].inst_b ? 14'(data_b) : data_a, vecs[i].exp_data);
      end

      // start_i held high: one IDLE cycle between conversions, nothing accepted while busy
      val_a = 14'h2A52;
      run_conv(1'b0, 1'b1, "hold1", lat);
      chk("hold1 latency", lat, 1031);
      chk("hold1 data", data_a, 14'h2A52);
      @(posedge clk); #1;
      chk("hold idle gap", {valid_a, busy_a}, 2'b00);
      @(posedge clk); #1;
      chk("hold restart", {busy_a, sh_a}, 2'b11);
      lat = 1;
      while (!valid_a && lat < 3000) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("hold2 latency", lat, 1031);
      chk("hold2 data", data_a, 14'h2A52);
      start_a = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("hold released idle", busy_a, 0);

      // Reset in the middle of shifting bit 7 (cycle 460 lies in 447..514)
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (459) @(posedge clk);
      #1;
      chk("mid shift busy/sh", {busy_a, sh_a}, 2'b10);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid reset outs", {sh_a, ser_a, sclk_a, lclk_a, busy_a, valid_a}, 6'b100000);
      chk("mid reset data", data_a, 0);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 1100; c++) begin
         @(posedge clk); #1;
         if (valid_a || busy_a) seen++;
      end
      chk("no valid after abort", seen, 0);
      run_conv(1'b0, 1'b0, "post reset", lat);
      chk("post reset latency", lat, 1031);
      chk("post reset data", data_a, 14'h2A52);
      chk("post reset lclk count", lclk_cnt_a, 14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
